// File: rtl/proc_run_controller_pkg.sv
// Shared FSM encoding and default timing constants for the run/check sequencer.
`default_nettype none

package proc_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } run_state_t;

  localparam int unsigned DEF_RESET_CYCLES   = 2;
  localparam int unsigned DEF_WATCHDOG_LIMIT = 32'h0000_00FF;
  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned HOLD_W             = 4;

endpackage

`default_nettype wire

// File: rtl/proc_run_controller_watchdog.sv
// Saturating run-cycle counter with an expiry flag raised when the count reaches LIMIT-1.
`default_nettype none

module run_watchdog #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LIMIT = 32'h0000_00FF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expiry looks at the pre-increment value, so the final count equals LIMIT.
  assign expire_o = (count_q == EXPIRE_AT);
  assign count_o  = count_q;

endmodule

`default_nettype wire

// File: rtl/proc_run_controller.sv
// Run/check sequencer: holds the core in reset, releases it at start_pc, stops at end_pc
// or on watchdog expiry, and grades the latched result against the expected value.
`default_nettype none

module proc_run_controller
  import proc_run_controller_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned WATCHDOG_LIMIT = DEF_WATCHDOG_LIMIT,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [63:0]      start_pc,
  input  logic [63:0]      end_pc,
  input  logic [63:0]      expected,
  output logic             proc_resetl,
  output logic [63:0]      proc_startpc,
  input  logic [63:0]      currentpc,
  input  logic [63:0]      memtoreg_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [63:0]      result,
  output logic [CNT_W-1:0] cycle_count
);

  run_state_t        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [63:0]       end_q;
  logic [63:0]       exp_q;
  logic [63:0]       startpc_q;
  logic [63:0]       result_q;
  logic              resetl_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;

  logic              start_ok;
  logic              pc_hit;
  logic              wd_expire;
  logic              wd_en;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pc_hit   = (currentpc >= end_q);
  assign wd_en    = (state_q == ST_RUN);

  run_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (WATCHDOG_LIMIT)
  ) u_watchdog (
    .clk_i    (CLK),
    .rst_i    (Reset),
    .clr_i    (start_ok),
    .en_i     (wd_en),
    .count_o  (cycle_count),
    .expire_o (wd_expire)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      end_q     <= '0;
      exp_q     <= '0;
      startpc_q <= '0;
      result_q  <= '0;
      resetl_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            startpc_q <= start_pc;
            end_q     <= end_pc;
            exp_q     <= expected;
            result_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            resetl_q  <= 1'b0;
            hold_q    <= HOLD_W'(RESET_CYCLES);
            state_q   <= ST_RESET_HOLD;
          end
        end
        ST_RESET_HOLD: begin
          // Leaving on the last hold cycle makes resetl rise with the first RUN cycle.
          if (hold_q <= HOLD_W'(1)) begin
            resetl_q <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (pc_hit) begin
            result_q <= memtoreg_out;
            pass_q   <= (memtoreg_out == exp_q);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            resetl_q <= 1'b0;
            state_q  <= ST_DONE;
          end else if (wd_expire) begin
            result_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            resetl_q  <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign proc_resetl  = resetl_q;
  assign proc_startpc = startpc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign result       = result_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_run_controller.sv
// Directed bench for proc_run_controller with a behavioural single-cycle core stand-in.
`default_nettype none

module tb_proc_run_controller;
  import proc_run_controller_pkg::*;

  localparam int MAX_WAIT = 400;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] start_pc = '0;
  logic [63:0] end_pc = '0;
  logic [63:0] expected = '0;
  logic        proc_resetl;
  logic [63:0] proc_startpc;
  logic [63:0] currentpc;
  logic [63:0] memtoreg_out;
  logic        busy, done, pass, timeout;
  logic [63:0] result;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int lat;
  int hold_lo;

  always #5 clk = ~clk;

  proc_run_controller dut (
    .CLK          (clk),
    .Reset        (Reset),
    .start        (start),
    .start_pc     (start_pc),
    .end_pc       (end_pc),
    .expected     (expected),
    .proc_resetl  (proc_resetl),
    .proc_startpc (proc_startpc),
    .currentpc    (currentpc),
    .memtoreg_out (memtoreg_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .result       (result),
    .cycle_count  (cycle_count)
  );

  // Core stand-in: PC parked at startpc while held, one 4-byte instruction per cycle after.
  function automatic logic [63:0] core_val(input logic [63:0] pc);
    case (pc)
      64'h30:  core_val = 64'hF;
      64'h5C:  core_val = 64'h1234_5678_9abc_def0;
      default: core_val = pc ^ 64'hA5A5_0000_0000_5A5A;
    endcase
  endfunction

  logic [63:0] core_pc = '0;
  always @(posedge clk) begin
    if (!proc_resetl) core_pc <= proc_startpc;
    else              core_pc <= core_pc + 64'd4;
  end
  assign currentpc    = core_pc;
  assign memtoreg_out = core_val(core_pc);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a run and wait (bounded) for done; lat counts negedges after acceptance.
  task automatic run(input logic [63:0] spc, input logic [63:0] epc, input logic [63:0] ex);
    @(negedge clk);
    start = 1'b1; start_pc = spc; end_pc = epc; expected = ex;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    hold_lo = 0;
    while (!done && lat < MAX_WAIT) begin
      if (busy && !proc_resetl) hold_lo++;
      @(negedge clk);
      lat++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_resetl"},  proc_resetl,  1'b0);
    check({tag, "_startpc"}, proc_startpc, 64'h0);
    check({tag, "_busy"},    busy,         1'b0);
    check({tag, "_done"},    done,         1'b0);
    check({tag, "_pass"},    pass,         1'b0);
    check({tag, "_timeout"}, timeout,      1'b0);
    check({tag, "_result"},  result,       64'h0);
    check({tag, "_count"},   cycle_count,  16'h0);
  endtask

  initial begin
    // 1: reset held three cycles
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    Reset = 1'b0;

    // 2: program 1, 0x00..0x30 -> 13 run cycles
    run(64'h0, 64'h30, 64'hF);
    check("p1_hold", hold_lo, DEF_RESET_CYCLES);
    check("p1_lat", lat, DEF_RESET_CYCLES + 13 + 1);
    check("p1_pass", pass, 1'b1);
    check("p1_timeout", timeout, 1'b0);
    check("p1_result", result, 64'hF);
    check("p1_count", cycle_count, 16'd13);
    check("p1_resetl", proc_resetl, 1'b0);
    check("p1_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("p1_done_hold", done, 1'b1);
    check("p1_count_hold", cycle_count, 16'd13);
    check("p1_result_hold", result, 64'hF);

    // 3: restart from DONE, 0x30..0x5C -> 12 run cycles
    run(64'h30, 64'h5C, 64'h1234_5678_9abc_def0);
    check("p2_startpc", proc_startpc, 64'h30);
    check("p2_hold", hold_lo, DEF_RESET_CYCLES);
    check("p2_lat", lat, DEF_RESET_CYCLES + 12 + 1);
    check("p2_pass", pass, 1'b1);
    check("p2_result", result, 64'h1234_5678_9abc_def0);
    check("p2_count", cycle_count, 16'd12);

    // 4: unreachable end PC -> watchdog
    run(64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0);
    check("wd_lat", lat, DEF_RESET_CYCLES + 255 + 1);
    check("wd_timeout", timeout, 1'b1);
    check("wd_pass", pass, 1'b0);
    check("wd_result", result, 64'h0);
    check("wd_count", cycle_count, 16'h00FF);

    // 5: wrong golden value
    run(64'h0, 64'h30, 64'hE);
    check("bad_pass", pass, 1'b0);
    check("bad_timeout", timeout, 1'b0);
    check("bad_result", result, 64'hF);
    check("bad_count", cycle_count, 16'd13);

    // end_pc below start_pc stops on the first run cycle
    run(64'h40, 64'h10, core_val(64'h40));
    check("early_count", cycle_count, 16'd1);
    check("early_pass", pass, 1'b1);
    check("early_result", result, core_val(64'h40));

    // 6: start during hold ignored, then reset mid-run
    @(negedge clk);
    start = 1'b1; start_pc = 64'h0; end_pc = 64'h30; expected = 64'hF;
    @(negedge clk);
    start_pc = 64'h30; end_pc = 64'h0;
    @(negedge clk);
    start = 1'b0;
    check("mid_startpc", proc_startpc, 64'h0);
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_done", done, 1'b0);
    check("mid_resetl", proc_resetl, 1'b1);
    check("mid_count", cycle_count, 16'd3);
    Reset = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_resetl", proc_resetl, 1'b0);
    check("idle_count", cycle_count, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
